// File: rtl/uart_pkg.sv
// Shared types and limits for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a UART word; shared by the TX framer and RX checker.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic              parity
);

    always_comb begin
        parity = 1'b0;
        case (parity_mode_e'(mode))
            PAR_EVEN: parity = ^data;
            PAR_ODD:  parity = ~^data;
            PAR_MARK: parity = 1'b1;
            default:  parity = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit serialiser: start, DATA_W bits LSB first, optional parity, 1 or 2 stops.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              baud_clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              data_tx,
    output logic              busy,
    output logic              done
);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
        $error("uart_tx_framer: DATA_W out of range");
    end

    tx_state_e         state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              par_bit;
    logic              par_en;
    logic              stop2_q;
    logic              par_new;
    logic              final_stop;

    uart_parity_gen #(.DATA_W(DATA_W)) u_par (
        .data   (tx_data),
        .mode   (parity_mode),
        .parity (par_new)
    );

    // The last stop cycle also accepts, so back-to-back frames have no idle gap.
    assign final_stop = (state == ST_STOP2) || (state == ST_STOP1 && !stop2_q);
    assign tx_ready   = (state == ST_IDLE) || final_stop;

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            par_en  <= 1'b0;
            stop2_q <= 1'b0;
            data_tx <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            state   <= ST_START;
            shreg   <= tx_data;
            par_bit <= par_new;
            par_en  <= (parity_mode != 2'b00);
            stop2_q <= stop2;
            data_tx <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    data_tx <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                ST_START: begin
                    state   <= ST_DATA;
                    data_tx <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        if (par_en) begin
                            state   <= ST_PARITY;
                            data_tx <= par_bit;
                        end else begin
                            state   <= ST_STOP1;
                            data_tx <= 1'b1;
                            done    <= !stop2_q;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        data_tx <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                ST_PARITY: begin
                    state   <= ST_STOP1;
                    data_tx <= 1'b1;
                    done    <= !stop2_q;
                end
                ST_STOP1: begin
                    if (stop2_q) begin
                        state   <= ST_STOP2;
                        data_tx <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        data_tx <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_STOP2: begin
                    state   <= ST_IDLE;
                    data_tx <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    data_tx <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: 8-bit and 7-bit instances, table vectors plus corner sequences.
module tb_uart_tx_framer;

    logic       baud_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_valid8 = 1'b0, tx_valid7 = 1'b0;
    logic [7:0] tx_data8 = '0;
    logic [6:0] tx_data7 = '0;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       tx_ready8, data_tx8, busy8, done8;
    logic       tx_ready7, data_tx7, busy7, done7;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 baud_clk = ~baud_clk;

    uart_tx_framer #(.DATA_W(8)) u_dut8 (
        .baud_clk(baud_clk), .rst_n(rst_n), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .tx_data(tx_data8), .parity_mode(parity_mode), .stop2(stop2),
        .data_tx(data_tx8), .busy(busy8), .done(done8)
    );

    uart_tx_framer #(.DATA_W(7)) u_dut7 (
        .baud_clk(baud_clk), .rst_n(rst_n), .tx_valid(tx_valid7), .tx_ready(tx_ready7),
        .tx_data(tx_data7), .parity_mode(parity_mode), .stop2(stop2),
        .data_tx(data_tx7), .busy(busy7), .done(done7)
    );

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  m;
        logic        s2;
        logic [11:0] exp;   // frame bits, bit 0 goes on the line first
        int          len;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference serialiser for the 8-bit instance.
    function automatic logic [11:0] ref_frame(input logic [7:0] d, input logic [1:0] m,
                                              input logic s2, output int len);
        logic [11:0] f;
        int idx;
        f = '0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        idx = 9;
        if (m != 2'b00) begin
            f[idx] = (m == 2'b01) ? ^d : (m == 2'b10) ? ~^d : 1'b1;
            idx++;
        end
        f[idx] = 1'b1;
        idx++;
        if (s2) begin
            f[idx] = 1'b1;
            idx++;
        end
        len = idx;
        return f;
    endfunction

    task automatic run_frame(input bit w7, input logic [7:0] d, input logic [1:0] m,
                             input logic s2, input logic [11:0] exp, input int len,
                             input bit chg, input logic [1:0] m_new, input logic s2_new);
        logic ln, bz, dn, rd;
        @(negedge baud_clk);
        parity_mode = m;
        stop2       = s2;
        if (w7) begin tx_data7 = d[6:0]; tx_valid7 = 1'b1; end
        else    begin tx_data8 = d;      tx_valid8 = 1'b1; end
        chk("ready_before_accept", w7 ? tx_ready7 : tx_ready8, 1'b1);
        @(posedge baud_clk);
        #1;
        tx_valid7 = 1'b0;
        tx_valid8 = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge baud_clk);
            ln = w7 ? data_tx7 : data_tx8;
            bz = w7 ? busy7 : busy8;
            dn = w7 ? done7 : done8;
            rd = w7 ? tx_ready7 : tx_ready8;
            chk($sformatf("line_bit%0d", i), ln, exp[i]);
            chk($sformatf("busy_bit%0d", i), bz, 1'b1);
            chk($sformatf("done_bit%0d", i), dn, (i == len - 1));
            chk($sformatf("ready_bit%0d", i), rd, (i == len - 1));
            if (chg && i == 3) begin
                parity_mode = m_new;
                stop2       = s2_new;
            end
        end
        @(negedge baud_clk);
        chk("idle_line", w7 ? data_tx7 : data_tx8, 1'b1);
        chk("idle_busy", w7 ? busy7 : busy8, 1'b0);
        chk("idle_done", w7 ? done7 : done8, 1'b0);
    endtask

    initial begin
        logic [11:0] rf;
        logic [19:0] b2b;
        logic [7:0]  rd8;
        logic [1:0]  rm;
        logic        rs;
        int          rl;

        vt[0] = '{8'hA5, 2'b00, 1'b0, {1'b1, 8'hA5, 1'b0}, 10};
        vt[1] = '{8'hA5, 2'b01, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vt[2] = '{8'hA5, 2'b10, 1'b1, {2'b11, 1'b1, 8'hA5, 1'b0}, 12};
        vt[3] = '{8'hA5, 2'b11, 1'b0, {1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vt[4] = '{8'h07, 2'b01, 1'b1, {2'b11, 1'b1, 8'h07, 1'b0}, 12};
        vt[5] = '{8'h00, 2'b10, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 11};
        vt[6] = '{8'hFF, 2'b00, 1'b1, {2'b11, 8'hFF, 1'b0}, 11};
        vt[7] = '{8'h80, 2'b01, 1'b0, {1'b1, 1'b1, 8'h80, 1'b0}, 11};

        // reset state
        #12;
        chk("rst_line", data_tx8, 1'b1);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        @(negedge baud_clk);
        rst_n = 1'b1;
        @(negedge baud_clk);
        chk("rst_ready", tx_ready8, 1'b1);
        chk("idle_line_no_accept", data_tx8, 1'b1);

        for (int k = 0; k < 8; k++)
            run_frame(1'b0, vt[k].d, vt[k].m, vt[k].s2, vt[k].exp, vt[k].len, 1'b0, 2'b00, 1'b0);

        // 7-bit, 0x41, odd parity, two stops
        run_frame(1'b1, 8'h41, 2'b10, 1'b1, {2'b11, 1'b1, 7'h41, 1'b0}, 11, 1'b0, 2'b00, 1'b0);

        // back-to-back 8N1: 0x00 then 0xFF with valid held
        b2b = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        @(negedge baud_clk);
        parity_mode = 2'b00;
        stop2       = 1'b0;
        tx_data8    = 8'h00;
        tx_valid8   = 1'b1;
        @(posedge baud_clk);
        #1;
        tx_data8 = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge baud_clk);
            chk($sformatf("b2b_line%0d", i), data_tx8, b2b[i]);
            chk($sformatf("b2b_busy%0d", i), busy8, 1'b1);
            chk($sformatf("b2b_done%0d", i), done8, (i == 9 || i == 19));
            if (i == 9) begin
                chk("b2b_ready_stop", tx_ready8, 1'b1);
                @(posedge baud_clk);
                #1;
                tx_valid8 = 1'b0;
            end
        end
        @(negedge baud_clk);
        chk("b2b_idle_busy", busy8, 1'b0);

        // reset during data bit 3 of 0x3C
        @(negedge baud_clk);
        tx_data8  = 8'h3C;
        tx_valid8 = 1'b1;
        @(posedge baud_clk);
        #1;
        tx_valid8 = 1'b0;
        repeat (4) @(negedge baud_clk);
        chk("mid_bit2", data_tx8, 1'b1);
        @(negedge baud_clk);
        chk("mid_bit3_busy", busy8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_line", data_tx8, 1'b1);
        chk("arst_busy", busy8, 1'b0);
        chk("arst_done", done8, 1'b0);
        @(negedge baud_clk);
        rst_n = 1'b1;
        @(negedge baud_clk);
        chk("post_rst_ready", tx_ready8, 1'b1);
        chk("post_rst_done", done8, 1'b0);
        chk("post_rst_line", data_tx8, 1'b1);
        run_frame(1'b0, 8'h55, 2'b00, 1'b0, {1'b1, 8'h55, 1'b0}, 10, 1'b0, 2'b00, 1'b0);

        // config change mid-frame is ignored; next frame uses it
        run_frame(1'b0, 8'hA5, 2'b01, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b1, 2'b10, 1'b1);
        run_frame(1'b0, 8'hA5, 2'b10, 1'b1, {2'b11, 1'b1, 8'hA5, 1'b0}, 12, 1'b0, 2'b00, 1'b0);

        // scoreboard frames against the reference serialiser
        for (int k = 0; k < 6; k++) begin
            rd8 = 8'($urandom);
            rm  = 2'($urandom_range(0, 3));
            rs  = 1'($urandom_range(0, 1));
            rf  = ref_frame(rd8, rm, rs, rl);
            run_frame(1'b0, rd8, rm, rs, rf, rl, 1'b0, 2'b00, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
